// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc,inst} entries; flush wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           pop_ok;
    logic           push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & !empty;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign push_ok = push & (!full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && push_ok) mem[wr_ptr] <= push_data;
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues in-order imem requests under a credit limit, queues
// responses with their PC, and drops responses that belong to a redirected stream.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [63:0] if_pc
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e   state, state_next;
    logic [63:0]    pc;
    logic [63:0]    resp_pc;
    logic [63:0]    target;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  outstanding_next;
    logic [OW-1:0]  stale;
    logic [OW-1:0]  stale_next;
    logic           req_fire;
    logic           rsp_fire;
    logic           q_push;
    logic           q_pop;
    logic           q_full;
    logic           q_empty;
    logic [CW-1:0]  q_count;
    fetch_entry_t   q_head;
    fetch_entry_t   q_in;

    assign target   = redirect_pc & ~64'h3;
    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_fire = imem_rsp_valid;

    // Queue slots plus in-flight requests never exceed DEPTH, so every response has room.
    assign imem_req_valid = (state != BOOT) && !redirect_valid && !q_full
                            && (outstanding < OW'(MAX_OUT))
                            && ((int'(q_count) + int'(outstanding)) < DEPTH);
    assign imem_req_addr  = pc;

    assign q_push = rsp_fire && (stale == '0) && !redirect_valid;
    assign q_pop  = if_valid && if_ready && !redirect_valid;
    assign q_in   = '{pc: resp_pc, inst: imem_rsp_data};

    assign if_valid = !q_empty;
    assign if_pc    = q_empty ? 64'h0 : q_head.pc;
    assign if_inst  = q_empty ? 32'h0 : q_head.inst;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_comb begin
        outstanding_next = outstanding + OW'(req_fire) - OW'(rsp_fire);
        stale_next       = stale;
        // Everything still in flight at a redirect belongs to the abandoned stream.
        if (redirect_valid)
            stale_next = outstanding - OW'(rsp_fire);
        else if (rsp_fire && (stale != '0))
            stale_next = stale - OW'(1);
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = (stale_next != '0) ? DRAIN : RUN;
        end else begin
            unique case (state)
                BOOT:    state_next = RUN;
                RUN:     state_next = RUN;
                DRAIN:   state_next = (stale_next == '0) ? RUN : DRAIN;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            stale       <= stale_next;
            if (redirect_valid) begin
                pc      <= target;
                resp_pc <= target;
            end else begin
                if (req_fire) pc      <= pc + 64'(INST_BYTES);
                if (q_push)   resp_pc <= resp_pc + 64'(INST_BYTES);
            end
        end
    end

endmodule
